// File: rtl/sync_fifo_pkg.sv
// Shared types for the synchronous FIFO: the occupancy flag bundle decoded from the count.
package sync_fifo_pkg;

    typedef struct packed {
        logic data_present;
        logic half_full;
        logic full;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake of the synchronous FIFO; master drives strobes, slave is the FIFO.
interface sync_fifo_if #(
    parameter int WIDTH = 8
);
    logic             write;
    logic             read;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] dataOut;
    logic             dataPresent;
    logic             halfFull;
    logic             full;

    modport master (
        output write, read, dataIn,
        input  dataOut, dataPresent, halfFull, full
    );

    modport slave (
        input  write, read, dataIn,
        output dataOut, dataPresent, halfFull, full
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, combinational read port.
module sync_fifo_ram #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LOG2_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [LOG2_DEPTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers and count,
    // so clearing the array would only cost a reset fan-out to every bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through single-clock FIFO with data-present, half-full and full flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);
    localparam logic [LOG2_DEPTH:0] DEPTH_C = {1'b1, {LOG2_DEPTH{1'b0}}};

    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH:0]   count;
    logic                  wr_ok;
    logic                  rd_ok;
    fifo_flags_t           flags;

    // Half full means count >= DEPTH/2, i.e. either of the top two count bits set.
    always_comb begin
        flags              = '0;
        flags.data_present = (count != '0);
        flags.half_full    = |count[LOG2_DEPTH -: 2];
        flags.full         = (count == DEPTH_C);
    end

    // A write into a full FIFO still lands when a read frees a slot in the same cycle.
    assign rd_ok = bus.read && flags.data_present;
    assign wr_ok = bus.write && (!flags.full || rd_ok);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_ram #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.dataIn),
        .raddr (rd_ptr),
        .rdata (bus.dataOut)
    );

    assign bus.dataPresent = flags.data_present;
    assign bus.halfFull    = flags.half_full;
    assign bus.full        = flags.full;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (WIDTH=8, DEPTH=16) with hand-computed expectations.
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   next_rd;
    int   next_wr;

    sync_fifo_if #(.WIDTH(8)) bus ();

    sync_fifo #(
        .WIDTH      (8),
        .LOG2_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply strobes for one clock, then sample 1 ns after the edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        bus.write  = w;
        bus.read   = r;
        bus.dataIn = d;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
    endtask

    initial begin
        bus.write  = 1'b0;
        bus.read   = 1'b0;
        bus.dataIn = '0;

        // Reset and idle
        rst = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 8'h00);
        check("rst_present", bus.dataPresent, 0);
        check("rst_half",    bus.halfFull,    0);
        check("rst_full",    bus.full,        0);

        // Reads while empty must not underflow the count
        repeat (3) cycle(1'b0, 1'b1, 8'h00);
        check("underflow_present", bus.dataPresent, 0);
        cycle(1'b1, 1'b0, 8'h77);
        check("single_present", bus.dataPresent, 1);
        check("single_data",    bus.dataOut,     8'h77);
        cycle(1'b0, 1'b1, 8'h00);
        check("single_drained", bus.dataPresent, 0);

        // Three writes then three reads
        cycle(1'b1, 1'b0, 8'h11);
        check("fwft_head", bus.dataOut, 8'h11);
        cycle(1'b1, 1'b0, 8'h22);
        cycle(1'b1, 1'b0, 8'h33);
        check("three_head", bus.dataOut, 8'h11);
        cycle(1'b0, 1'b1, 8'h00);
        check("three_rd1", bus.dataOut, 8'h22);
        cycle(1'b0, 1'b1, 8'h00);
        check("three_rd2", bus.dataOut, 8'h33);
        cycle(1'b0, 1'b1, 8'h00);
        check("three_empty", bus.dataPresent, 0);

        // Fill to DEPTH, watching half-full and full thresholds
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i - 1));
            check($sformatf("fill_half_%0d", i), bus.halfFull, (i >= 8) ? 1 : 0);
            check($sformatf("fill_full_%0d", i), bus.full,     (i == 16) ? 1 : 0);
        end
        cycle(1'b1, 1'b0, 8'hFF);
        check("overflow_full", bus.full,    1);
        check("overflow_head", bus.dataOut, 8'h00);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), bus.dataOut, 32'(i));
            cycle(1'b0, 1'b1, 8'h00);
        end
        check("drain_empty", bus.dataPresent, 0);
        check("drain_half",  bus.halfFull,    0);

        // Full FIFO with simultaneous write and read
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i));
        check("both_full_pre", bus.full, 1);
        cycle(1'b1, 1'b1, 8'hAA);
        check("both_full_post", bus.full,    1);
        check("both_full_head", bus.dataOut, 8'h01);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("both_drain_%0d", i), bus.dataOut, 32'(i));
            cycle(1'b0, 1'b1, 8'h00);
        end
        check("both_last", bus.dataOut, 8'hAA);
        cycle(1'b0, 1'b1, 8'h00);
        check("both_empty", bus.dataPresent, 0);

        // Empty FIFO with simultaneous write and read: write lands, read ignored
        cycle(1'b1, 1'b1, 8'h5C);
        check("empty_both_present", bus.dataPresent, 1);
        check("empty_both_data",    bus.dataOut,     8'h5C);
        cycle(1'b0, 1'b1, 8'h00);
        check("empty_both_drain", bus.dataPresent, 0);

        // Stream 40 words, reading on 3 of every 4 cycles; write pointer wraps twice
        next_rd = 0;
        next_wr = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 4 != 0) begin
                check($sformatf("stream_%0d", next_rd), bus.dataOut, 32'(8'h80 + next_rd));
                cycle(1'b1, 1'b1, 8'(8'h80 + next_wr));
                next_rd++;
            end else begin
                cycle(1'b1, 1'b0, 8'(8'h80 + next_wr));
            end
            next_wr++;
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stream_%0d", next_rd), bus.dataOut, 32'(8'h80 + next_rd));
            cycle(1'b0, 1'b1, 8'h00);
            next_rd++;
        end
        check("stream_held", bus.dataPresent, 1);

        // Reset with five words held, then only new data comes out
        rst = 1'b1;
        cycle(1'b1, 1'b1, 8'hEE);
        rst = 1'b0;
        check("midrst_present", bus.dataPresent, 0);
        check("midrst_half",    bus.halfFull,    0);
        check("midrst_full",    bus.full,        0);
        cycle(1'b1, 1'b0, 8'h3C);
        check("postrst_data",    bus.dataOut,     8'h3C);
        check("postrst_present", bus.dataPresent, 1);
        cycle(1'b0, 1'b1, 8'h00);
        check("postrst_empty", bus.dataPresent, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
